// File: rtl/gf_power_sbox_seq.sv
// gf_power_sbox_seq: sequential GF(2^N) power-map S-box (MSB-first square-and-multiply) with affine broadcast tweak
module gf_power_sbox_seq #(
  parameter int N = 6,
  parameter logic [N:0] POLY = 7'b1000011,
  parameter int EW = 6,
  parameter logic [N-1:0] TAP_MASK = 6'b010100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [N-1:0]  in_x_i,
  input  logic [EW-1:0] in_exp_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [N-1:0]  out_y_o,
  output logic [N-1:0]  out_p_o,
  output logic          busy_o
);
  localparam int CW = EW > 1 ? $clog2(EW) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e        state_q;
  logic [N-1:0]  acc_q, acc_d, sq_d, x_q, out_y_q, out_p_q;
  logic [EW-1:0] e_q;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q, busy_q, tweak_d;
  function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r, t;
    r = '0;
    t = a;
    for (int i = 0; i < N; i++) begin
      if (b[i]) r = r ^ t;
      t = t[N-1] ? ((t << 1) ^ POLY[N-1:0]) : (t << 1);
    end
    return r;
  endfunction
  // one square-and-multiply step for the current exponent bit, plus the tweak parity of the captured operand
  always_comb begin
    sq_d    = gf_mul(acc_q, acc_q);
    acc_d   = e_q[cnt_q] ? gf_mul(sq_d, x_q) : sq_d;
    tweak_d = ^(x_q & TAP_MASK);
  end
  // IDLE -> RUN on accept, EW RUN steps, DONE holds the result until the sink takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      x_q         <= '0;
      e_q         <= '0;
      out_y_q     <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid_i) begin
          x_q     <= in_x_i;
          e_q     <= in_exp_i;
          acc_q   <= N'(1);
          cnt_q   <= CW'(EW - 1);
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            out_p_q     <= acc_d;
            out_y_q     <= acc_d ^ {N{tweak_d}};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else cnt_q <= cnt_q - 1'b1;
        end
        DONE: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready_o  = state_q == IDLE;
  assign out_valid_o = out_valid_q;
  assign out_y_o     = out_y_q;
  assign out_p_o     = out_p_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_gf_power_sbox_seq.sv
// tb_gf_power_sbox_seq: directed and random checks of the power S-box against a behavioural GF(64) model
module tb_gf_power_sbox_seq;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready, in_ready, out_valid, busy;
  logic [5:0] in_x, in_exp, out_y, out_p;
  int total = 0, bad = 0, cyc = 0;

  gf_power_sbox_seq #(.N(6), .POLY(7'b1000011), .EW(6), .TAP_MASK(6'b010100)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x), .in_exp_i(in_exp),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_y_o(out_y), .out_p_o(out_p),
    .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gmul(input int a, input int b);
    int r = 0;
    for (int i = 0; i < 6; i++) if ((b >> i) & 1) r ^= a << i;
    for (int i = 10; i >= 6; i--) if ((r >> i) & 1) r ^= 'h43 << (i - 6);
    return r;
  endfunction

  function automatic int gpow(input int x, input int e);
    int p = 1;
    for (int k = 0; k < e; k++) p = gmul(p, x);
    return p;
  endfunction

  function automatic int sbox(input int x, input int e);
    return gpow(x, e) ^ ((((x >> 4) ^ (x >> 2)) & 1) ? 'h3F : 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // starts at a negedge in IDLE, ends at the negedge after the DONE handshake
  task automatic do_op(input logic [5:0] x, input logic [5:0] e, input int hold,
                       output logic [5:0] p_o, output logic [5:0] y_o);
    int lat;
    check("idle_ready", in_ready, 1);
    in_valid = 1; in_x = x; in_exp = e; out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; in_x = 6'($urandom); in_exp = 6'($urandom);
    check("run_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    check("latency", lat, 6);
    check("out_p", out_p, gpow(x, e));
    check("out_y", out_y, sbox(x, e));
    p_o = out_p; y_o = out_y;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1; in_x = 6'($urandom); in_exp = 6'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_p", out_p, p_o);
      check("hold_y", out_y, y_o);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
    check("release_busy", busy, 0);
    check("keep_p", out_p, p_o);
  endtask

  initial begin
    logic [5:0] p, y, bx[4], be[4];
    int acc_cyc[4], lat, seen;
    rst_n = 0; in_valid = 0; out_ready = 0; in_x = 0; in_exp = 0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_p", out_p, 0);
    check("rst_out_y", out_y, 0);
    #20;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_op(6'h02, 6'd19, 0, p, y); check("t1_p", p, 6'h1E); check("t1_y", y, 6'h1E);
    do_op(6'h04, 6'd1, 0, p, y);  check("t2_p", p, 6'h04); check("t2_y", y, 6'h3B);
    do_op(6'h02, 6'd63, 0, p, y); check("t2_wrap", p, 6'h01);
    do_op(6'h00, 6'd0, 0, p, y);  check("t3_00", p, 6'h01);
    do_op(6'h00, 6'd19, 0, p, y); check("t3_0e_p", p, 6'h00); check("t3_0e_y", y, 6'h00);
    do_op(6'h01, 6'd19, 0, p, y); check("t3_1e", p, 6'h01);
    do_op(6'h15, 6'd37, 5, p, y);
    in_valid = 1; in_x = 6'h02; in_exp = 6'd19;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    seen = 0;
    repeat (3) begin @(negedge clk); seen |= int'(out_valid); end
    rst_n = 1;
    repeat (10) begin @(negedge clk); seen |= int'(out_valid); end
    check("abort_no_valid", seen, 0);
    do_op(6'h02, 6'd19, 0, p, y); check("after_abort_p", p, 6'h1E);
    for (int i = 0; i < 20; i++) do_op(6'($urandom), 6'($urandom), int'($urandom_range(0, 3)), p, y);
    for (int i = 0; i < 4; i++) begin
      bx[i] = 6'(($urandom & 'h3C) | i);
      be[i] = 6'($urandom);
    end
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_x = bx[i]; in_exp = be[i];
      check("b2b_ready", in_ready, 1);
      @(posedge clk);
      acc_cyc[i] = cyc;
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
      check("b2b_latency", lat, 6);
      check("b2b_p", out_p, gpow(bx[i], be[i]));
      check("b2b_y", out_y, sbox(bx[i], be[i]));
      if (i > 0) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 8);
      if (i == 3) in_valid = 0;
      @(negedge clk);
    end
    check("b2b_end_valid", out_valid, 0);
    check("b2b_end_ready", in_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
